// File: rtl/ifu_pkg.sv
// Shared types and defaults for the instruction fetch unit.
// Holds the fetch FSM state encoding and the default datapath widths.
package ifu_pkg;

  localparam int IFU_XLEN    = 32;
  localparam int IFU_IMEM_AW = 10;
  localparam int IFU_CNT_W   = 32;

  typedef enum logic [1:0] {
    IFU_IDLE,
    IFU_REQ,
    IFU_HOLD,
    IFU_DROP
  } ifu_state_e;

  // Both REQ and DROP own an outstanding imem read.
  function automatic logic ifu_req_state(input ifu_state_e s);
    return (s == IFU_REQ) || (s == IFU_DROP);
  endfunction

endpackage

// File: rtl/ifu_sat_counter.sv
// Saturating up-counter with increment enable.
// Sticks at all-ones instead of wrapping.
module ifu_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: reads the PC, fetches over imem req/ack, hands words to decode.
// Optional IFU_STALL_CNT_EN adds the stall_cycles counter port.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int XLEN    = IFU_XLEN,
  parameter int IMEM_AW = IFU_IMEM_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  input  logic [XLEN-1:0]    pc_address,
  input  logic               redirect,
  output logic               inc_pc,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [XLEN-1:0]    imem_rdata,
  output logic [XLEN-1:0]    instr,
  output logic [XLEN-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready
`ifdef IFU_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cycles
`endif
);

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            instr_valid_q, instr_valid_d;

  // Redirect always wins over ack and handshake, and yields exactly one inc_pc pulse.
  always_comb begin
    state_d       = state_q;
    req_pc_d      = req_pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    inc_pc        = 1'b0;

    unique case (state_q)
      IFU_IDLE: begin
        if (redirect) begin
          inc_pc = 1'b1;
        end else if (fetch_en) begin
          state_d  = IFU_REQ;
          req_pc_d = pc_address;
        end
      end

      IFU_REQ: begin
        if (redirect) begin
          inc_pc  = 1'b1;
          state_d = imem_ack ? IFU_IDLE : IFU_DROP;
        end else if (imem_ack) begin
          inc_pc        = 1'b1;
          instr_d       = imem_rdata;
          instr_pc_d    = req_pc_q;
          instr_valid_d = 1'b1;
          state_d       = IFU_HOLD;
        end
      end

      IFU_HOLD: begin
        if (redirect) begin
          inc_pc        = 1'b1;
          instr_valid_d = 1'b0;
          state_d       = IFU_IDLE;
        end else if (instr_ready) begin
          instr_valid_d = 1'b0;
          if (fetch_en) begin
            state_d  = IFU_REQ;
            req_pc_d = pc_address;
          end else begin
            state_d = IFU_IDLE;
          end
        end
      end

      // The orphaned read must still complete before a new address may be issued.
      IFU_DROP: begin
        if (redirect) begin
          inc_pc = 1'b1;
        end
        if (imem_ack) begin
          if (!redirect && fetch_en) begin
            state_d  = IFU_REQ;
            req_pc_d = pc_address;
          end else begin
            state_d = IFU_IDLE;
          end
        end
      end

      default: begin
        state_d = IFU_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IFU_IDLE;
      req_pc_q      <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_pc_q      <= req_pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign imem_req    = ifu_req_state(state_q);
  assign imem_addr   = req_pc_q[IMEM_AW-1:0];
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;

`ifdef IFU_STALL_CNT_EN
  logic stall_inc;

  // A stall is any cycle spent waiting on imem, including reads being thrown away.
  assign stall_inc = ((state_q == IFU_REQ) && !imem_ack) || (state_q == IFU_DROP);

  ifu_sat_counter #(
    .W(IFU_CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (stall_inc),
    .count(stall_cycles)
  );
`endif

endmodule
